// File: rtl/ext_irq_ctrl_if.sv
// Core-side data-store snoop bus and
// interrupt request/acknowledge handshake.
interface ext_irq_ctrl_if #(
  parameter int N    = 64,
  parameter int NSRC = 4
);
  localparam int IW = $clog2(NSRC);

  logic [N-1:0]  DM_addr;
  logic [N-1:0]  DM_writeData;
  logic          DM_writeEnable;
  logic          ExtIAck;
  logic          ExtIRQ;
  logic [IW-1:0] irq_id;

  modport master (
    output DM_addr,
    output DM_writeData,
    output DM_writeEnable,
    output ExtIAck,
    input  ExtIRQ,
    input  irq_id
  );

  modport slave (
    input  DM_addr,
    input  DM_writeData,
    input  DM_writeEnable,
    input  ExtIAck,
    output ExtIRQ,
    output irq_id
  );
endinterface

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synced edge
// capture, MMIO mask/clear, 4-phase handshake.
module ext_irq_ctrl #(
  parameter int          N         = 64,
  parameter int          NSRC      = 4,
  parameter logic [N-1:0] MASK_ADDR = 64'h400,
  parameter logic [N-1:0] CLR_ADDR  = 64'h408
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  ext_irq_ctrl_if.slave   bus,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);
  localparam int IW = $clog2(NSRC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAITLOW
  } state_t;

  state_t          r_state;
  logic            r_irq;
  logic [IW-1:0]   r_id;
  logic [NSRC-1:0] r_s1;
  logic [NSRC-1:0] r_s2;
  logic [NSRC-1:0] r_s3;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;

  logic [NSRC-1:0] w_rise;
  logic            w_mask_wr;
  logic            w_clr_wr;
  logic [NSRC-1:0] w_mmio_clr;
  logic [NSRC-1:0] w_hs_clr;
  logic [NSRC-1:0] w_elig;
  logic            w_any;
  logic [IW-1:0]   w_low;
  logic            w_unused;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_mask_wr = bus.DM_writeEnable &&
                     (bus.DM_addr == MASK_ADDR);
  assign w_clr_wr  = bus.DM_writeEnable &&
                     (bus.DM_addr == CLR_ADDR);
  assign w_mmio_clr = w_clr_wr ?
                      bus.DM_writeData[NSRC-1:0] : '0;
  assign w_hs_clr  = (r_state == REQ && bus.ExtIAck) ?
                     (NSRC'(1) << r_id) : '0;
  assign w_elig    = r_pending & r_mask;
  assign w_any     = |w_elig;
  assign w_unused  = &{1'b0, bus.DM_writeData[N-1:NSRC]};

  // Two-flop synchronizer plus edge-history flop.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= irq_src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pending: a fresh edge beats any clear in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_mmio_clr & ~w_hs_clr)
                   | w_rise;
    end
  end

  // Software mask register, write-only over the store bus.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_mask <= '0;
    end else if (w_mask_wr) begin
      r_mask <= bus.DM_writeData[NSRC-1:0];
    end
  end

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    w_low = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_low = IW'(i);
    end
  end

  // Request/ack handshake; once raised the request is never retracted.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
      r_id    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id    <= w_low;
            r_irq   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus.ExtIAck) begin
            r_irq   <= 1'b0;
            r_state <= WAITLOW;
          end
        end
        WAITLOW: begin
          if (!bus.ExtIAck) r_state <= IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ExtIRQ = r_irq;
  assign bus.irq_id = r_id;
  assign pending    = r_pending;
  assign mask       = r_mask;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed and random checks of ext_irq_ctrl
// against a cycle-level behavioural model.
module tb_ext_irq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_src;
  logic [3:0] pending;
  logic [3:0] mask;
  int         tests = 0;
  int         fails = 0;

  ext_irq_ctrl_if #(.N(64), .NSRC(4)) bus ();

  ext_irq_ctrl #(
    .N(64), .NSRC(4),
    .MASK_ADDR(64'h400), .CLR_ADDR(64'h408)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst_n),
    .irq_src(irq_src),
    .bus(bus),
    .pending(pending),
    .mask(mask)
  );

  always #5 clk = ~clk;

  // Model: samples of irq_src seen at the last three edges.
  logic [3:0] m_h0, m_h1, m_h2;
  logic [3:0] m_pend, m_mask;
  bit         m_irq, m_wait;
  int         m_id;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] rise, clr, hs, elig;
    logic [3:0] n_pend, n_mask;
    bit n_irq, n_wait;
    int n_id;
    n_pend = m_pend; n_mask = m_mask;
    n_irq = m_irq; n_wait = m_wait; n_id = m_id;
    if (!rst_n) begin
      n_pend = 0; n_mask = 0;
      n_irq = 0; n_wait = 0; n_id = 0;
    end else begin
      rise = m_h1 & ~m_h2;
      clr = (bus.DM_writeEnable &&
             bus.DM_addr == 64'h408) ?
            bus.DM_writeData[3:0] : 4'h0;
      hs = (m_irq && bus.ExtIAck) ?
           4'(1 << m_id) : 4'h0;
      n_pend = (m_pend & ~clr & ~hs) | rise;
      if (bus.DM_writeEnable && bus.DM_addr == 64'h400)
        n_mask = bus.DM_writeData[3:0];
      if (m_irq) begin
        if (bus.ExtIAck) begin
          n_irq = 0; n_wait = 1;
        end
      end else if (m_wait) begin
        if (!bus.ExtIAck) n_wait = 0;
      end else begin
        elig = m_pend & m_mask;
        if (elig != 0) begin
          n_irq = 1;
          n_id = 0;
          while (!elig[n_id]) n_id++;
        end
      end
    end
    if (!rst_n) begin
      m_h2 = 0; m_h1 = 0; m_h0 = 0;
    end else begin
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = irq_src;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_mask = n_mask;
    m_irq = n_irq; m_wait = n_wait; m_id = n_id;
    chk("model_irq", 64'(bus.ExtIRQ), 64'(m_irq));
    chk("model_id", 64'(bus.irq_id), 64'(m_id));
    chk("model_pend", 64'(pending), 64'(m_pend));
    chk("model_mask", 64'(mask), 64'(m_mask));
  endtask

  task automatic wr(input logic [63:0] a,
                    input logic [63:0] d);
    bus.DM_writeEnable = 1'b1;
    bus.DM_addr = a;
    bus.DM_writeData = d;
    tick();
    bus.DM_writeEnable = 1'b0;
    bus.DM_addr = '0;
    bus.DM_writeData = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_h0 = 0; m_h1 = 0; m_h2 = 0;
    m_pend = 0; m_mask = 0;
    m_irq = 0; m_wait = 0; m_id = 0;
    rst_n = 1'b0;
    irq_src = 4'hF;
    bus.DM_addr = '0;
    bus.DM_writeData = '0;
    bus.DM_writeEnable = 1'b0;
    bus.ExtIAck = 1'b0;
    #2;

    // 1: reset, then edges latch but mask blocks request
    ticks(2);
    chk("rst_irq", 64'(bus.ExtIRQ), 64'h0);
    chk("rst_pend", 64'(pending), 64'h0);
    chk("rst_mask", 64'(mask), 64'h0);
    rst_n = 1'b1;
    ticks(3);
    chk("t1_pend", 64'(pending), 64'hF);
    ticks(2);
    chk("t1_noirq", 64'(bus.ExtIRQ), 64'h0);
    irq_src = 4'h0;
    wr(64'h408, 64'hF);
    chk("t1_clr", 64'(pending), 64'h0);
    ticks(2);

    // 2: single source, full handshake, E+2 latency
    wr(64'h400, 64'hF);
    irq_src = 4'h4;
    tick();
    chk("t2_e0", 64'(pending), 64'h0);
    tick();
    chk("t2_e1", 64'(pending), 64'h0);
    tick();
    chk("t2_e2", 64'(pending), 64'h4);
    chk("t2_e2irq", 64'(bus.ExtIRQ), 64'h0);
    irq_src = 4'h0;
    tick();
    chk("t2_irq", 64'(bus.ExtIRQ), 64'h1);
    chk("t2_id", 64'(bus.irq_id), 64'h2);
    bus.ExtIAck = 1'b1;
    tick();
    chk("t2_ackirq", 64'(bus.ExtIRQ), 64'h0);
    chk("t2_ackpend", 64'(pending), 64'h0);
    bus.ExtIAck = 1'b0;
    ticks(3);

    // 3: two sources at once, lowest first, one-cycle gap
    irq_src = 4'hA;
    ticks(3);
    chk("t3_pend", 64'(pending), 64'hA);
    tick();
    chk("t3_id1", 64'(bus.irq_id), 64'h1);
    bus.ExtIAck = 1'b1;
    tick();
    chk("t3_pend8", 64'(pending), 64'h8);
    bus.ExtIAck = 1'b0;
    tick();
    chk("t3_gap", 64'(bus.ExtIRQ), 64'h0);
    tick();
    chk("t3_irq2", 64'(bus.ExtIRQ), 64'h1);
    chk("t3_id3", 64'(bus.irq_id), 64'h3);
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    irq_src = 4'h0;
    ticks(3);

    // 4: masked source pends but never requests
    wr(64'h400, 64'hE);
    irq_src = 4'h1;
    ticks(3);
    chk("t4_pend", 64'(pending), 64'h1);
    tick();
    chk("t4_noirq", 64'(bus.ExtIRQ), 64'h0);
    irq_src = 4'h0;
    wr(64'h408, 64'h1);
    chk("t4_clr", 64'(pending), 64'h0);
    tick();
    chk("t4_noirq2", 64'(bus.ExtIRQ), 64'h0);

    // 5: clear during REQ, edge beats clear
    wr(64'h400, 64'hF);
    irq_src = 4'h4;
    ticks(4);
    chk("t5_irq", 64'(bus.ExtIRQ), 64'h1);
    irq_src = 4'h0;
    wr(64'h408, 64'h4);
    chk("t5_clrpend", 64'(pending), 64'h0);
    chk("t5_hold", 64'(bus.ExtIRQ), 64'h1);
    ticks(3);
    irq_src = 4'h4;
    ticks(2);
    wr(64'h408, 64'h4);
    chk("t5_edgewin", 64'(pending), 64'h4);
    chk("t5_hold2", 64'(bus.ExtIRQ), 64'h1);
    bus.ExtIAck = 1'b1;
    tick();
    chk("t5_drop", 64'(bus.ExtIRQ), 64'h0);
    bus.ExtIAck = 1'b0;
    irq_src = 4'h0;
    ticks(3);

    // 6: reset during REQ, then held ack
    irq_src = 4'h2;
    ticks(4);
    chk("t6_req", 64'(bus.ExtIRQ), 64'h1);
    irq_src = 4'h0;
    rst_n = 1'b0;
    tick();
    chk("t6_irq", 64'(bus.ExtIRQ), 64'h0);
    chk("t6_pend", 64'(pending), 64'h0);
    rst_n = 1'b1;
    bus.ExtIAck = 1'b1;
    ticks(4);
    chk("t6_noreq", 64'(bus.ExtIRQ), 64'h0);
    bus.ExtIAck = 1'b0;

    // random traffic against the model
    wr(64'h400, 64'hF);
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0)
          irq_src[b] = ~irq_src[b];
      if ($urandom_range(0, 2) == 0)
        bus.ExtIAck = ~bus.ExtIAck;
      bus.DM_writeEnable = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: bus.DM_addr = 64'h400;
        1: bus.DM_addr = 64'h408;
        2: bus.DM_addr = 64'h410;
        default: bus.DM_addr = 64'h1400;
      endcase
      bus.DM_writeData = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- External interrupt controller that sits directly upstream of processor_arm.
- Collects NSRC level-or-pulse interrupt sources, latches rising edges into a pending register and applies a software mask.
- Drives the core's ExtIRQ input and completes a four-phase handshake on the core's ExtIAck output.
- Mask and pending-clear are memory-mapped on the core's data-memory write bus (DM_addr / DM_writeData / DM_writeEnable); the block snoops that bus alongside dmem.

Parameters:
- N, 64, data-bus and address width.
- NSRC, 4, number of interrupt sources (2..16).
- MASK_ADDR, 64'h400, byte address of the mask register (write-only here).
- CLR_ADDR, 64'h408, byte address of the pending write-1-to-clear register.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets).
- irq_src  in  NSRC  asynchronous interrupt request lines, active high.
- DM_addr  in  N  core data address.
- DM_writeData  in  N  core store data.
- DM_writeEnable  in  1  core store strobe.
- ExtIAck  in  1  acknowledge from core.
- ExtIRQ  out  1  interrupt request to core.
- irq_id  out  $clog2(NSRC)  index of the source being requested; valid while ExtIRQ==1.
- pending  out  NSRC  current pending register (debug/observe).
- mask  out  NSRC  current mask register; 1 = enabled.

Behaviour:
- Reset (reset==0 at a rising edge): synchronizers, edge history, pending=0, mask=0, irq_id=0, ExtIRQ=0, FSM=IDLE. Reset applied mid-handshake forces IDLE with ExtIRQ=0 on that edge; the pending request is lost.
- Input path: two-flop synchronizer per source, then edge detect against a third flop (rise = s2 & ~s3).
  - A source going high before edge E sets its pending bit at edge E+2, visible after E+2.
  - A level held high sets pending only once. A pulse shorter than one clock period may be missed; that is acceptable.
- MMIO (evaluated every cycle; DM_writeEnable==1 and exact full-width address match only):
  - MASK_ADDR: mask <= DM_writeData[NSRC-1:0].
  - CLR_ADDR: pending bits set in DM_writeData[NSRC-1:0] are cleared.
  - Any other address is ignored.
- Pending update priority within one cycle: new edge set > MMIO clear > handshake clear. A bit both edge-set and cleared in the same cycle ends up 1.
- Eligible = pending & mask. Priority is fixed: lowest index wins.
- FSM:
  - IDLE: if eligible!=0, latch irq_id = lowest eligible index and go to REQ. ExtIRQ rises on the same edge, so it is visible one cycle after eligibility is seen.
  - REQ: ExtIRQ=1, irq_id stable. When ExtIAck==1, clear pending[irq_id], drop ExtIRQ on that edge and go to WAITLOW.
  - REQ, masked or cleared: if pending[irq_id] is cleared or masked while in REQ, still wait for ExtIAck (no retraction). The core owns the request once it is raised.
  - WAITLOW: ExtIRQ=0; stay until ExtIAck==0, then go to IDLE.
  - Minimum gap between consecutive requests is one IDLE cycle.
- ExtIAck==1 observed in IDLE is ignored.
- irq_id holds its last value outside REQ.
- Widths: DM_writeData bits above NSRC-1 are ignored. irq_id is zero-extended where NSRC is not a power of two.

Test Plan:
1. Reset with reset=0 for 2 cycles, irq_src=4'b1111 -> ExtIRQ=0, pending=0, mask=0. After release with no mask write, pending becomes 4'b1111 but ExtIRQ stays 0.
2. Store 64'hF to 64'h400, then pulse irq_src[2] (3 cycles) -> pending=4'b0100 at E+2, ExtIRQ=1 and irq_id=2 on the next edge. ExtIAck=1 then clears pending to 0 and drops ExtIRQ. ExtIAck=0 returns the FSM to IDLE.
3. mask=4'b1111, raise irq_src[3] and irq_src[1] in the same cycle -> first request irq_id=1. After its handshake completes, a second request with irq_id=3 after a 1-cycle IDLE gap.
4. mask=4'b1110, raise irq_src[0] -> pending=4'b0001, no ExtIRQ. Then store 64'h1 to 64'h408 -> pending=0, still no ExtIRQ.
5. In REQ with irq_id=2, store 64'h4 to 64'h408 -> ExtIRQ stays 1 until ExtIAck=1. An edge on source 2 in the same cycle as the clear leaves pending[2]=1.
6. Assert reset=0 while in REQ -> ExtIRQ=0 and pending=0 after that edge. Holding ExtIAck=1 after reset produces no request.
